// File: rtl/etai_pkg.sv
// Shared definitions for the ETAI error monitor: FSM state type and
// default sizing constants.
package etai_pkg;

  localparam int ETAI_N_DEFAULT     = 16;
  localparam int ETAI_CNT_W_DEFAULT = 32;

  // Measurement-window controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } etai_state_e;

endpackage

// File: rtl/etai_ed_calc.sv
// Combinational error-distance calculator: exact sum X+Y against the
// approximate result {Cout,S}, giving |exact - approx| as N+1 unsigned bits.
module etai_ed_calc #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] s,
  input  logic         cout,
  output logic [N:0]   ed
);

  logic [N:0] exact;
  logic [N:0] approx;

  // Exact sum and absolute difference against the approximate adder output
  always_comb begin
    exact  = {1'b0, x} + {1'b0, y};
    approx = {cout, s};
    if (exact >= approx) ed = exact - approx;
    else                 ed = approx - exact;
  end

endmodule

// File: rtl/etai_error_monitor.sv
// Error-distance monitor for an approximate (ETAI) adder. Accepts a window
// of X/Y/S/Cout samples and accumulates sample count, error count, ED sum
// and ED maximum through a 2-stage pipeline (stage 1: ED, stage 2: update).
// Optional feature: define ETAI_SQERR_EN to add the sq_sum output
// accumulating ED*ED.
module etai_error_monitor
  import etai_pkg::*;
#(
  parameter int N     = ETAI_N_DEFAULT,
  parameter int CNT_W = ETAI_CNT_W_DEFAULT,
  localparam int ACC_W = CNT_W + N + 1
`ifdef ETAI_SQERR_EN
  ,
  localparam int SQ_W  = 2 * (N + 1) + CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     X,
  input  logic [N-1:0]     Y,
  input  logic [N-1:0]     S,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  input  logic             ack,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N:0]       ed_max
`ifdef ETAI_SQERR_EN
  ,
  output logic [SQ_W-1:0]  sq_sum
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Control state
  etai_state_e      state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_inc;
  logic             drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_ok;
  logic             ready;
  logic             xfer;

  // Pipeline
  logic [N:0]       ed_p0;
  logic             vld_p1_q, vld_p1_d;
  logic [N:0]       ed_p1_q, ed_p1_d;
  logic             nz_p1_q, nz_p1_d;

  // Accumulators
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic [N:0]       ed_max_q, ed_max_d;
`ifdef ETAI_SQERR_EN
  logic [2*(N+1)-1:0] sq_p1;
  logic [SQ_W-1:0]    sq_sum_q, sq_sum_d;
`endif

  // Handshake: ready only while the window still needs samples
  always_comb begin
    ready   = (state_q == ST_RUN) && (acc_q < num_q);
    xfer    = in_valid && ready;
    acc_inc = acc_q + CNT_ONE;
  end

  assign in_ready = ready;

  // Window FSM; start in IDLE or DONE restarts, start wins over ack
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    acc_d    = acc_q;
    drain_d  = drain_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) start_ok = 1'b1;
      end
      ST_RUN: begin
        if (xfer) begin
          acc_d = acc_inc;
          if (acc_inc == num_q) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // Two cycles: enough for the last sample to clear both stages
        drain_d = 1'b1;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start)    start_ok = 1'b1;
        else if (ack) state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      num_d   = num_samples;
      acc_d   = '0;
      drain_d = 1'b0;
      state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
    end
    busy_d = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done_d = (state_q == ST_DONE);
  end

  // Stage 0 -> 1: error distance of the accepted sample
  etai_ed_calc #(.N(N)) u_ed_calc (
    .x    (X),
    .y    (Y),
    .s    (S),
    .cout (Cout),
    .ed   (ed_p0)
  );

  // Stage 1 next-state: capture ED and its nonzero flag
  always_comb begin
    vld_p1_d = xfer;
    ed_p1_d  = ed_p0;
    nz_p1_d  = |ed_p0;
  end

`ifdef ETAI_SQERR_EN
  // Squared error of the stage-1 sample
  always_comb begin
    sq_p1 = {{(N+1){1'b0}}, ed_p1_q} * {{(N+1){1'b0}}, ed_p1_q};
  end
`endif

  // Stage 1 -> 2: accumulate; a new window clears everything
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_sum_d     = ed_sum_q;
    ed_max_d     = ed_max_q;
`ifdef ETAI_SQERR_EN
    sq_sum_d     = sq_sum_q;
`endif
    if (start_ok) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_sum_d     = '0;
      ed_max_d     = '0;
`ifdef ETAI_SQERR_EN
      sq_sum_d     = '0;
`endif
    end else if (vld_p1_q) begin
      sample_cnt_d = sample_cnt_q + CNT_ONE;
      err_cnt_d    = err_cnt_q + {{(CNT_W-1){1'b0}}, nz_p1_q};
      ed_sum_d     = ed_sum_q + {{(ACC_W-N-1){1'b0}}, ed_p1_q};
      if (ed_p1_q > ed_max_q) ed_max_d = ed_p1_q;
`ifdef ETAI_SQERR_EN
      sq_sum_d     = sq_sum_q + {{CNT_W{1'b0}}, sq_p1};
`endif
    end
  end

  // Control, valid bit and accumulator registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      acc_q        <= '0;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_p1_q     <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
`ifdef ETAI_SQERR_EN
      sq_sum_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      acc_q        <= acc_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vld_p1_q     <= vld_p1_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_sum_q     <= ed_sum_d;
      ed_max_q     <= ed_max_d;
`ifdef ETAI_SQERR_EN
      sq_sum_q     <= sq_sum_d;
`endif
    end
  end

  // Stage-1 data registers; qualified by vld_p1_q so no reset needed
  always_ff @(posedge clk) begin
    ed_p1_q <= ed_p1_d;
    nz_p1_q <= nz_p1_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;
`ifdef ETAI_SQERR_EN
  assign sq_sum     = sq_sum_q;
`endif

endmodule

// File: tb/tb_etai_error_monitor.sv
// Testbench for etai_error_monitor: directed windows plus randomized
// windows checked against a window-level reference model.
module tb_etai_error_monitor;

  localparam int N     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = CNT_W + N + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     X, Y, S;
  logic             Cout;
  logic             busy, done, ack;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] ed_sum;
  logic [N:0]       ed_max;
`ifdef ETAI_SQERR_EN
  logic [2*(N+1)+CNT_W-1:0] sq_sum;
`endif

  etai_error_monitor #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .X           (X),
    .Y           (Y),
    .S           (S),
    .Cout        (Cout),
    .busy        (busy),
    .done        (done),
    .ack         (ack),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .ed_sum      (ed_sum),
    .ed_max      (ed_max)
`ifdef ETAI_SQERR_EN
    ,
    .sq_sum      (sq_sum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: window bookkeeping and the list of accepted EDs
  int     m_num, m_acc, m_since;
  bit     m_run, m_fin;
  longint q_ed[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint ed_of(input logic [15:0] x, input logic [15:0] y, input logic [16:0] app);
    longint e, a;
    e = longint'(x) + longint'(y);
    a = longint'(app);
    return (e > a) ? (e - a) : (a - e);
  endfunction

  // One clock cycle of stimulus; checks in_ready, done and sample_cnt
  task automatic feed(input bit v, input logic [15:0] x, input logic [15:0] y, input logic [16:0] app);
    bit rdy_exp;
    int pre;
    in_valid  = v;
    X         = x;
    Y         = y;
    {Cout, S} = app;
    rdy_exp = m_run && (m_acc < m_num);
    check_eq("in_ready", in_ready, rdy_exp);
    pre = m_acc;
    if (v && rdy_exp) begin
      q_ed.push_back(ed_of(x, y, app));
      m_acc++;
      if (m_acc == m_num) begin
        m_run   = 1'b0;
        m_fin   = 1'b1;
        m_since = -1;
      end
    end
    @(posedge clk); #1;
    if (m_fin) m_since++;
    check_eq("sample_cnt_pipe", sample_cnt, pre);
    check_eq("done", done, (m_fin && m_since >= 3));
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int num, input bit with_ack);
    start       = 1'b1;
    ack         = with_ack;
    num_samples = num;
    in_valid    = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    ack     = 1'b0;
    m_num   = num;
    m_acc   = 0;
    q_ed.delete();
    m_run   = (num != 0);
    m_fin   = (num == 0);
    m_since = 2;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack   = 1'b0;
    m_fin = 1'b0;
    m_run = 1'b0;
  endtask

  task automatic run_drain();
    for (int k = 0; k < 8 && !(m_fin && m_since >= 3); k++) feed(1'b0, 16'h0, 16'h0, 17'h0);
    check_eq("done_reached", done, 1'b1);
    check_eq("busy_in_done", busy, 1'b0);
  endtask

  task automatic check_results();
    longint cnt, err, sum, mx, sq;
    cnt = q_ed.size(); err = 0; sum = 0; mx = 0; sq = 0;
    foreach (q_ed[i]) begin
      if (q_ed[i] != 0) err++;
      sum += q_ed[i];
      if (q_ed[i] > mx) mx = q_ed[i];
      sq += q_ed[i] * q_ed[i];
    end
    check_eq("sample_cnt", sample_cnt, cnt);
    check_eq("err_cnt", err_cnt, err);
    check_eq("ed_sum", ed_sum, sum);
    check_eq("ed_max", ed_max, mx);
`ifdef ETAI_SQERR_EN
    check_eq("sq_sum", sq_sum, sq);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sample_cnt"}, sample_cnt, 0);
    check_eq({tag, "_err_cnt"}, err_cnt, 0);
    check_eq({tag, "_ed_sum"}, ed_sum, 0);
    check_eq({tag, "_ed_max"}, ed_max, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic rand_sample(output logic [15:0] x, output logic [15:0] y, output logic [16:0] app);
    logic [16:0] ex;
    x  = 16'($urandom);
    y  = 16'($urandom);
    ex = {1'b0, x} + {1'b0, y};
    case ($urandom_range(0, 2))
      0:       app = ex;
      1:       app = ex ^ 17'($urandom_range(0, 255));
      default: app = 17'($urandom);
    endcase
  endtask

  initial begin
    logic [15:0] vx[5];
    logic [15:0] vy[5];
    logic [16:0] va[5];
    logic [15:0] rx, ry;
    logic [16:0] ra;
    int acc_seen;

    vx = '{16'h0800, 16'h00FF, 16'hFFFF, 16'h5555, 16'h0FFF};
    vy = '{16'h0801, 16'h00FF, 16'hFFFF, 16'hAAAA, 16'h0FFF};
    va = '{17'h01001, 17'h000FF, 17'h1FEFF, 17'h0FFFF, 17'h01EFF};

    rst = 1'b1; start = 1'b0; ack = 1'b0; num_samples = '0;
    in_valid = 1'b0; X = '0; Y = '0; S = '0; Cout = 1'b0;
    m_num = 0; m_acc = 0; m_since = 0; m_run = 1'b0; m_fin = 1'b0;

    // Reset state, before any clock edge
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    feed(1'b1, 16'h1, 16'h1, 17'h0);   // in_valid in IDLE is ignored

    // Directed 5-sample window
    do_start(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      feed(1'b1, vx[i], vy[i], va[i]);
      if (i == 0) check_eq("busy_in_run", busy, 1'b1);
    end
    run_drain();
    check_results();
    check_eq("vec_err_cnt", err_cnt, 3);
    check_eq("vec_ed_sum", ed_sum, 765);
    check_eq("vec_ed_max", ed_max, 255);
`ifdef ETAI_SQERR_EN
    check_eq("vec_sq_sum", sq_sum, 195075);
`endif
    do_ack();
    feed(1'b0, 16'h0, 16'h0, 17'h0);
    check_eq("ack_retains_cnt", sample_cnt, 5);

    // Zero-length window
    do_start(0, 1'b0);
    run_drain();
    check_results();
    do_ack();
    feed(1'b0, 16'h0, 16'h0, 17'h0);

    // in_valid held high for 10 cycles with a 3-sample window
    do_start(3, 1'b0);
    acc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      rand_sample(rx, ry, ra);
      feed(1'b1, rx, ry, ra);
    end
    check_eq("hold_transfers", sample_cnt, 3);
    check_results();

    // start+ack together in DONE restarts with cleared accumulators
    do_start(1, 1'b1);
    check_eq("restart_sample_cnt", sample_cnt, 0);
    check_eq("restart_ed_sum", ed_sum, 0);
    check_eq("restart_ed_max", ed_max, 0);
    start = 1'b1;                    // ignored while RUN
    num_samples = 7;
    feed(1'b1, 16'h00FF, 16'h00FF, 17'h000FF);
    start = 1'b0;
    run_drain();
    check_results();
    check_eq("start_in_run_cnt", sample_cnt, 1);
    do_ack();

    // Randomized windows, alternating ack and direct restart
    for (int w = 0; w < 6; w++) begin
      do_start($urandom_range(1, 8), 1'b0);
      for (int c = 0; c < 80 && !m_fin; c++) begin
        rand_sample(rx, ry, ra);
        feed(($urandom_range(0, 9) < 6), rx, ry, ra);
      end
      check_eq("window_complete", m_fin, 1'b1);
      run_drain();
      check_results();
      if (w[0]) do_ack();
    end
    if (done) do_ack();

    // Asynchronous reset in the middle of a window
    do_start(4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rand_sample(rx, ry, ra);
      feed(1'b1, rx, ry, ra);
    end
    rst = 1'b1;
    #2;
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_run = 1'b0; m_fin = 1'b0; m_acc = 0; m_num = 0; q_ed.delete();
    feed(1'b0, 16'h0, 16'h0, 17'h0);
    do_start(1, 1'b0);
    feed(1'b1, 16'h00FF, 16'h00FF, 17'h000FF);
    run_drain();
    check_results();
    check_eq("post_reset_ed_sum", ed_sum, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total simulation time
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/etai_error_monitor.md
ETAI_ERROR_MONITOR -- requirements
Module: etai_error_monitor

Interface
REQ-001 SHALL have parameter N, default 16, operand/sum width of the monitored ETAI.
REQ-002 SHALL have parameter CNT_W, default 32, sample and error counter width.
REQ-003 SHALL derive localparam ACC_W = CNT_W+N+1, the ED-sum width, which cannot overflow by construction.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a measurement window; clears all accumulators.
REQ-007 num_samples  input  CNT_W  window length, latched on accepted start.
REQ-008 in_valid  input  1  X/Y/S/Cout sample valid.
REQ-009 in_ready  output  1  monitor accepts a sample this cycle.
REQ-010 X, Y  input  N each  operands applied to the ETAI.
REQ-011 S  input  N  approximate sum from the ETAI; Cout  input  1  its carry-out.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 done  output  1  results final; level, held until ack or start.
REQ-014 ack  input  1  release DONE.
REQ-015 sample_cnt, err_cnt  output  CNT_W each  samples accepted, samples with ED != 0.
REQ-016 ed_sum  output  ACC_W  sum of error distances; ed_max  output  N+1  largest ED.

Function
REQ-017 SHALL compute per sample exact = X+Y (N+1 bits), approx = {Cout,S}, ED = |exact-approx| (N+1 bits, unsigned).
REQ-018 SHALL use a 2-stage pipeline: stage 1 registers ED and an ED!=0 flag; stage 2 updates accumulators; results visible 2 cycles after the accepting edge.
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 -> clear accumulators, latch num_samples, go to RUN; if num_samples=0, go directly to DONE with all results zero.
REQ-021 RUN: in_ready = (accepted < latched num_samples); a transfer occurs when in_valid && in_ready; the transfer that makes the count equal num_samples moves the FSM to DRAIN.
REQ-022 DRAIN: in_ready=0; lasts exactly 2 cycles (pipeline flush), then DONE.
REQ-023 DONE: done=1, in_ready=0; ack=1 -> IDLE with results retained; start=1 (priority over ack) -> restart as in REQ-020.
REQ-024 start SHALL be ignored in RUN and DRAIN; in_valid without in_ready SHALL be ignored.
REQ-025 ed_max SHALL update only when the new ED is strictly greater than the current ed_max.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs except in_ready from FSM state/count.

Reset
REQ-027 rst=1 SHALL force IDLE, clear pipeline valid bits, and zero sample_cnt, err_cnt, ed_sum, ed_max, busy, done, in_ready, independent of clk.
REQ-028 Reset mid-RUN or mid-DRAIN SHALL discard in-flight samples; first post-reset start behaves as from power-up.

Configuration
REQ-029 With ETAI_SQERR_EN defined, SHALL add output sq_sum (2*(N+1)+CNT_W bits) accumulating ED*ED in stage 2, cleared with the other accumulators.
REQ-030 Without ETAI_SQERR_EN, sq_sum port, multiplier and register SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package etai_pkg SHALL hold the FSM state enum type and default N/CNT_W constants.
REQ-032 One sub-module etai_ed_calc (combinational exact-sum and |exact-approx|, parameter N) SHALL be instantiated in stage 1.

Verification
REQ-033 start, num_samples=5; samples (X,Y,{Cout,S}): (0x0800,0x0801,0x01001), (0x00FF,0x00FF,0x000FF), (0xFFFF,0xFFFF,0x1FEFF), (0x5555,0xAAAA,0x0FFFF), (0x0FFF,0x0FFF,0x01EFF) -> done, sample_cnt=5, err_cnt=3, ed_sum=765, ed_max=255, sq_sum=195075 if enabled.
REQ-034 start with num_samples=0 -> DONE next cycle, all results 0, in_ready never high.
REQ-035 num_samples=3, in_valid held high for 10 cycles -> exactly 3 transfers; in_ready low from the 3rd accepting edge; done exactly 3 cycles after it.
REQ-036 rst pulsed after 2 of 4 samples -> immediate IDLE, all outputs 0; new start of 1 sample (0x00FF,0x00FF,0x000FF) -> ed_sum=255.
REQ-037 In DONE, start and ack together with num_samples=1 -> RUN, accumulators zeroed; start asserted during RUN -> no effect on counts.
